xy_switch_allocator: RTL and testbench

- Per-router switch allocator for the 2D mesh: decides, every cycle, which input port drives each output port of the 5x5 crossbar.
- Routes each input's head flit through one xy_router instance per input, arbitrates round-robin between heads contending for the same output, and holds a wormhole lock on that output until the packet's tail flit has passed.
- Sits between the input buffers (which present flits and addresses) and the crossbar mux selects / output link registers.

---
 rtl/xy_switch_allocator_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 40 ++++
 rtl/xy_router.sv | 37 +++
 rtl/xy_switch_allocator.sv | 167 ++++++++++++++++
 tb/tb_xy_switch_allocator.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/xy_switch_allocator_pkg.sv
// Shared definitions for the mesh router: port IDs, default port counts,
// output-allocation state and the round-robin pointer increment.
package xy_switch_allocator_pkg;

    localparam int unsigned PORT_N_DEF   = 5;
    localparam int unsigned PORT_N_W_DEF = 3;

    // Port IDs, identical numbering for inputs and outputs
    localparam int unsigned PORT_RESOURCE = 0;
    localparam int unsigned PORT_LEFT     = 1;
    localparam int unsigned PORT_UP       = 2;
    localparam int unsigned PORT_RIGHT    = 3;
    localparam int unsigned PORT_DOWN     = 4;

    typedef enum logic {
        OUT_IDLE   = 1'b0,
        OUT_LOCKED = 1'b1
    } out_state_e;

    // Next port index after idx, wrapping at n
    function automatic int unsigned next_port(input int unsigned idx, input int unsigned n);
        return ((idx + 32'd1) >= n) ? 32'd0 : (idx + 32'd1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first request at or after ptr_i, modulo PORT_N.
// Ports:
//   req_i      request vector
//   ptr_i      highest-priority index this cycle
//   en_i       allow a grant
//   gnt_c_o    one-hot grant (combinational)
//   winner_c_o index of the granted requester, 0 if none (combinational)
module rr_arbiter
    import xy_switch_allocator_pkg::*;
#(
    parameter int unsigned PORT_N   = PORT_N_DEF,
    parameter int unsigned PORT_N_W = PORT_N_W_DEF
) (
    input  logic [PORT_N-1:0]   req_i,
    input  logic [PORT_N_W-1:0] ptr_i,
    input  logic                en_i,
    output logic [PORT_N-1:0]   gnt_c_o,
    output logic [PORT_N_W-1:0] winner_c_o
);

    logic                found_c;
    logic [PORT_N_W-1:0] cand_c;

    // Scan PORT_N candidates starting at the pointer, keep the first hit
    always_comb begin
        gnt_c_o    = '0;
        winner_c_o = '0;
        found_c    = 1'b0;
        cand_c     = '0;
        for (int unsigned k = 0; k < PORT_N; k++) begin
            cand_c = PORT_N_W'((32'(ptr_i) + k) % PORT_N);
            if (en_i && !found_c && req_i[cand_c]) begin
                found_c         = 1'b1;
                gnt_c_o[cand_c] = 1'b1;
                winner_c_o      = cand_c;
            end
        end
    end

endmodule

// File: rtl/xy_router.sv
// XY dimension-order routing: resolve column first, then row.
// Ports:
//   col_addr_i   destination column
//   row_addr_i   destination row
//   out_port_c_o output port ID (combinational)
module xy_router
    import xy_switch_allocator_pkg::*;
#(
    parameter int unsigned COL_CORD   = 0,
    parameter int unsigned ROW_CORD   = 0,
    parameter int unsigned COL_ADDR_W = 4,
    parameter int unsigned ROW_ADDR_W = 4,
    parameter int unsigned PORT_N_W   = PORT_N_W_DEF
) (
    input  logic [COL_ADDR_W-1:0] col_addr_i,
    input  logic [ROW_ADDR_W-1:0] row_addr_i,
    output logic [PORT_N_W-1:0]   out_port_c_o
);

    localparam logic [COL_ADDR_W-1:0] MY_COL = COL_ADDR_W'(COL_CORD);
    localparam logic [ROW_ADDR_W-1:0] MY_ROW = ROW_ADDR_W'(ROW_CORD);

    // Larger column is to the right, larger row is downward
    always_comb begin
        out_port_c_o = PORT_N_W'(PORT_RESOURCE);
        if (col_addr_i > MY_COL) begin
            out_port_c_o = PORT_N_W'(PORT_RIGHT);
        end else if (col_addr_i < MY_COL) begin
            out_port_c_o = PORT_N_W'(PORT_LEFT);
        end else if (row_addr_i > MY_ROW) begin
            out_port_c_o = PORT_N_W'(PORT_DOWN);
        end else if (row_addr_i < MY_ROW) begin
            out_port_c_o = PORT_N_W'(PORT_UP);
        end
    end

endmodule

// File: rtl/xy_switch_allocator.sv
// Switch allocator for one mesh router: routes each input head flit,
// round-robin arbitrates per output and holds a wormhole lock on the output
// until the packet tail has passed.
// Ports:
//   clk_i, rst_i  clock, asynchronous active-high reset
//   valid_i       per input: flit present
//   head_i/tail_i per input: head / tail flit markers
//   col_addr_i    per input: destination column (head only)
//   row_addr_i    per input: destination row (head only)
//   out_ready_i   per output: downstream can accept
//   grant_o       per input: flit transfers this cycle
//   out_valid_o   per output: carries a flit this cycle
//   xbar_sel_o    per output: driving input index, 0 when idle
module xy_switch_allocator
    import xy_switch_allocator_pkg::*;
#(
    parameter int unsigned COL_CORD   = 0,
    parameter int unsigned ROW_CORD   = 0,
    parameter int unsigned COL_ADDR_W = 4,
    parameter int unsigned ROW_ADDR_W = 4,
    parameter int unsigned PORT_N     = PORT_N_DEF,
    parameter int unsigned PORT_N_W   = PORT_N_W_DEF
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [PORT_N-1:0]            valid_i,
    input  logic [PORT_N-1:0]            head_i,
    input  logic [PORT_N-1:0]            tail_i,
    input  logic [PORT_N*COL_ADDR_W-1:0] col_addr_i,
    input  logic [PORT_N*ROW_ADDR_W-1:0] row_addr_i,
    input  logic [PORT_N-1:0]            out_ready_i,
    output logic [PORT_N-1:0]            grant_o,
    output logic [PORT_N-1:0]            out_valid_o,
    output logic [PORT_N*PORT_N_W-1:0]   xbar_sel_o
);

    out_state_e          state_q  [PORT_N];
    out_state_e          state_d  [PORT_N];
    logic [PORT_N_W-1:0] owner_q  [PORT_N];
    logic [PORT_N_W-1:0] owner_d  [PORT_N];
    logic [PORT_N_W-1:0] rr_ptr_q [PORT_N];
    logic [PORT_N_W-1:0] rr_ptr_d [PORT_N];

    logic [PORT_N_W-1:0] route_c  [PORT_N];
    logic [PORT_N-1:0]   req_c    [PORT_N];
    logic [PORT_N-1:0]   arb_gnt_c[PORT_N];
    logic [PORT_N_W-1:0] arb_win_c[PORT_N];
    logic [PORT_N-1:0]   arb_en_c;
    logic [PORT_N-1:0]   bound_c;
    logic [PORT_N-1:0]   out_gnt_c;
    logic [PORT_N_W-1:0] out_sel_c[PORT_N];

    // One router per input, one arbiter per output
    for (genvar gi = 0; gi < PORT_N; gi++) begin : g_port
        xy_router #(
            .COL_CORD  (COL_CORD),
            .ROW_CORD  (ROW_CORD),
            .COL_ADDR_W(COL_ADDR_W),
            .ROW_ADDR_W(ROW_ADDR_W),
            .PORT_N_W  (PORT_N_W)
        ) u_router (
            .col_addr_i  (col_addr_i[gi*COL_ADDR_W +: COL_ADDR_W]),
            .row_addr_i  (row_addr_i[gi*ROW_ADDR_W +: ROW_ADDR_W]),
            .out_port_c_o(route_c[gi])
        );

        rr_arbiter #(
            .PORT_N  (PORT_N),
            .PORT_N_W(PORT_N_W)
        ) u_arb (
            .req_i     (req_c[gi]),
            .ptr_i     (rr_ptr_q[gi]),
            .en_i      (arb_en_c[gi]),
            .gnt_c_o   (arb_gnt_c[gi]),
            .winner_c_o(arb_win_c[gi])
        );
    end

    // Bound inputs only follow their lock; unbound heads request their route
    always_comb begin
        bound_c  = '0;
        arb_en_c = '0;
        for (int unsigned o = 0; o < PORT_N; o++) begin
            if (state_q[o] == OUT_LOCKED) begin
                bound_c[owner_q[o]] = 1'b1;
            end
            arb_en_c[o] = (state_q[o] == OUT_IDLE) && out_ready_i[o];
        end
        for (int unsigned o = 0; o < PORT_N; o++) begin
            req_c[o] = '0;
            for (int unsigned i = 0; i < PORT_N; i++) begin
                req_c[o][i] = valid_i[i] & head_i[i] & ~bound_c[i] &
                              (route_c[i] == PORT_N_W'(o));
            end
        end
    end

    // Per-output FSM next state and grant decision
    always_comb begin
        for (int unsigned o = 0; o < PORT_N; o++) begin
            state_d[o]   = state_q[o];
            owner_d[o]   = owner_q[o];
            rr_ptr_d[o]  = rr_ptr_q[o];
            out_sel_c[o] = '0;
        end
        out_gnt_c = '0;
        for (int unsigned o = 0; o < PORT_N; o++) begin
            case (state_q[o])
                OUT_IDLE: begin
                    if (|arb_gnt_c[o]) begin
                        out_gnt_c[o] = 1'b1;
                        out_sel_c[o] = arb_win_c[o];
                        rr_ptr_d[o]  = PORT_N_W'(next_port(32'(arb_win_c[o]), PORT_N));
                        if (!tail_i[arb_win_c[o]]) begin
                            state_d[o] = OUT_LOCKED;
                            owner_d[o] = arb_win_c[o];
                        end
                    end
                end
                OUT_LOCKED: begin
                    if (valid_i[owner_q[o]] && out_ready_i[o]) begin
                        out_gnt_c[o] = 1'b1;
                        out_sel_c[o] = owner_q[o];
                        if (tail_i[owner_q[o]]) begin
                            state_d[o] = OUT_IDLE;
                        end
                    end
                end
                default: state_d[o] = OUT_IDLE;
            endcase
        end
    end

    // Outputs are forced to zero while reset is held
    always_comb begin
        grant_o     = '0;
        out_valid_o = '0;
        xbar_sel_o  = '0;
        if (!rst_i) begin
            for (int unsigned o = 0; o < PORT_N; o++) begin
                if (out_gnt_c[o]) begin
                    out_valid_o[o]                       = 1'b1;
                    grant_o[out_sel_c[o]]                = 1'b1;
                    xbar_sel_o[o*PORT_N_W +: PORT_N_W]   = out_sel_c[o];
                end
            end
        end
    end

    // State registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned o = 0; o < PORT_N; o++) begin
                state_q[o]  <= OUT_IDLE;
                owner_q[o]  <= '0;
                rr_ptr_q[o] <= '0;
            end
        end else begin
            for (int unsigned o = 0; o < PORT_N; o++) begin
                state_q[o]  <= state_d[o];
                owner_q[o]  <= owner_d[o];
                rr_ptr_q[o] <= rr_ptr_d[o];
            end
        end
    end

endmodule

// File: tb/tb_xy_switch_allocator.sv
// Bench for xy_switch_allocator at router (1,1): directed scenarios with
// literal expectations, then randomized traffic against a packet-level model.
module tb_xy_switch_allocator;

    localparam int unsigned N  = 5;
    localparam int unsigned W  = 3;
    localparam int unsigned CW = 4;
    localparam int unsigned RW = 4;
    localparam int unsigned MY_C = 1;
    localparam int unsigned MY_R = 1;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    valid, head, tail, ready;
    logic [N*CW-1:0] col;
    logic [N*RW-1:0] row;
    logic [N-1:0]    grant, oval;
    logic [N*W-1:0]  sel;

    always #5 clk = ~clk;

    xy_switch_allocator #(
        .COL_CORD(MY_C), .ROW_CORD(MY_R), .COL_ADDR_W(CW), .ROW_ADDR_W(RW),
        .PORT_N(N), .PORT_N_W(W)
    ) dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .head_i(head), .tail_i(tail),
        .col_addr_i(col), .row_addr_i(row), .out_ready_i(ready),
        .grant_o(grant), .out_valid_o(oval), .xbar_sel_o(sel)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Model: per output, whether it is held by a packet, by whom, and whose turn is next
    bit          m_locked[N], n_locked[N];
    int unsigned m_owner[N], n_owner[N];
    int unsigned m_ptr[N], n_ptr[N];
    logic [N-1:0]   exp_grant, exp_oval;
    logic [N*W-1:0] exp_sel;

    // Dimension-order: travel horizontally until the column matches, then vertically
    function automatic int unsigned dest_port(input int unsigned c, input int unsigned r);
        if (c > MY_C) return 3;
        if (c < MY_C) return 1;
        if (r > MY_R) return 4;
        if (r < MY_R) return 2;
        return 0;
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_eval();
        bit          bound[N];
        bit          found;
        int unsigned ow, cand;
        exp_grant = '0;
        exp_oval  = '0;
        exp_sel   = '0;
        for (int o = 0; o < N; o++) begin
            n_locked[o] = m_locked[o];
            n_owner[o]  = m_owner[o];
            n_ptr[o]    = m_ptr[o];
            bound[o]    = 1'b0;
        end
        if (rst) begin
            for (int o = 0; o < N; o++) begin
                n_locked[o] = 1'b0;
                n_owner[o]  = 0;
                n_ptr[o]    = 0;
            end
            return;
        end
        for (int o = 0; o < N; o++) if (m_locked[o]) bound[m_owner[o]] = 1'b1;
        for (int o = 0; o < N; o++) begin
            if (m_locked[o]) begin
                ow = m_owner[o];
                if (valid[ow] && ready[o]) begin
                    exp_grant[ow]      = 1'b1;
                    exp_oval[o]        = 1'b1;
                    exp_sel[o*W +: W]  = W'(ow);
                    if (tail[ow]) n_locked[o] = 1'b0;
                end
            end else if (ready[o]) begin
                found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    cand = (m_ptr[o] + k) % N;
                    if (!found && valid[cand] && head[cand] && !bound[cand] &&
                        dest_port(col[cand*CW +: CW], row[cand*RW +: RW]) == o) begin
                        found               = 1'b1;
                        exp_grant[cand]     = 1'b1;
                        exp_oval[o]         = 1'b1;
                        exp_sel[o*W +: W]   = W'(cand);
                        n_ptr[o]            = (cand + 1) % N;
                        if (!tail[cand]) begin
                            n_locked[o] = 1'b1;
                            n_owner[o]  = cand;
                        end
                    end
                end
            end
        end
    endtask

    // Called just after inputs are driven at the falling edge
    task automatic cycle(input bit lit, input logic [N-1:0] lg, input logic [N-1:0] lo,
                         input logic [N*W-1:0] ls, input string nm);
        #1;
        model_eval();
        cmp({nm, " grant"},    32'(grant), 32'(exp_grant));
        cmp({nm, " out_valid"}, 32'(oval), 32'(exp_oval));
        cmp({nm, " xbar_sel"}, 32'(sel),   32'(exp_sel));
        if (lit) begin
            cmp({nm, " grant(lit)"},     32'(grant), 32'(lg));
            cmp({nm, " out_valid(lit)"}, 32'(oval),  32'(lo));
            cmp({nm, " xbar_sel(lit)"},  32'(sel),   32'(ls));
        end
        for (int o = 0; o < N; o++) begin
            m_locked[o] = n_locked[o];
            m_owner[o]  = n_owner[o];
            m_ptr[o]    = n_ptr[o];
        end
    endtask

    task automatic clear_in();
        valid = '0;
        head  = '0;
        tail  = '0;
        col   = '0;
        row   = '0;
        ready = '1;
    endtask

    task automatic set_flit(input int unsigned i, input bit h, input bit t,
                            input int unsigned c, input int unsigned r);
        valid[i]         = 1'b1;
        head[i]          = h;
        tail[i]          = t;
        col[i*CW +: CW]  = CW'(c);
        row[i*RW +: RW]  = RW'(r);
    endtask

    // Random traffic sources
    int unsigned p_len[N], p_pos[N], p_c[N], p_r[N];
    bit          p_act[N];
    int          rst_cnt;

    initial begin
        for (int o = 0; o < N; o++) begin
            m_locked[o] = 1'b0;
            m_owner[o]  = 0;
            m_ptr[o]    = 0;
        end
        rst = 1'b1;
        clear_in();

        // Reset gating and idle
        @(negedge clk); set_flit(0, 1, 1, 3, 1);
        cycle(1'b1, 5'b00000, 5'b00000, 15'd0, "reset");
        @(negedge clk); rst = 1'b0; clear_in();
        cycle(1'b1, 5'b00000, 5'b00000, 15'd0, "idle");

        // Single-flit to RIGHT
        @(negedge clk); clear_in(); set_flit(0, 1, 1, 3, 1);
        cycle(1'b1, 5'b00001, 5'b01000, 15'd0, "t1 single");
        @(negedge clk); clear_in();
        cycle(1'b1, 5'b00000, 5'b00000, 15'd0, "t1 after");

        // Contention on RESOURCE, pointer advances to 3
        @(negedge clk); clear_in(); set_flit(1, 1, 1, 1, 1); set_flit(2, 1, 1, 1, 1);
        cycle(1'b1, 5'b00010, 5'b00001, 15'd1, "t2 c0");
        @(negedge clk); clear_in(); set_flit(2, 1, 1, 1, 1);
        cycle(1'b1, 5'b00100, 5'b00001, 15'd2, "t2 c1");
        @(negedge clk); clear_in(); set_flit(0, 1, 1, 1, 1); set_flit(1, 1, 1, 1, 1);
        cycle(1'b1, 5'b00001, 5'b00001, 15'd0, "t2 ptr wrap");
        @(negedge clk); clear_in(); set_flit(1, 1, 1, 1, 1);
        cycle(1'b1, 5'b00010, 5'b00001, 15'd1, "t2 c3");

        // Wormhole on LEFT
        @(negedge clk); clear_in(); set_flit(1, 1, 0, 0, 1);
        cycle(1'b1, 5'b00010, 5'b00010, 15'd8, "t3 head");
        for (int b = 0; b < 2; b++) begin
            @(negedge clk); clear_in(); set_flit(1, 0, 0, 9, 9); set_flit(4, 1, 1, 0, 1);
            cycle(1'b1, 5'b00010, 5'b00010, 15'd8, "t3 body");
        end
        @(negedge clk); clear_in(); set_flit(1, 0, 1, 9, 9); set_flit(4, 1, 1, 0, 1);
        cycle(1'b1, 5'b00010, 5'b00010, 15'd8, "t3 tail");
        @(negedge clk); clear_in(); set_flit(4, 1, 1, 0, 1);
        cycle(1'b1, 5'b10000, 5'b00010, 15'd32, "t3 next");

        // Backpressure mid-packet on RIGHT
        @(negedge clk); clear_in(); set_flit(0, 1, 0, 3, 1);
        cycle(1'b1, 5'b00001, 5'b01000, 15'd0, "t4 head");
        @(negedge clk); clear_in(); set_flit(0, 0, 0, 0, 0);
        cycle(1'b1, 5'b00001, 5'b01000, 15'd0, "t4 body");
        for (int b = 0; b < 3; b++) begin
            @(negedge clk); clear_in(); set_flit(0, 0, 0, 0, 0); set_flit(2, 1, 1, 3, 1);
            ready[3] = 1'b0;
            cycle(1'b1, 5'b00000, 5'b00000, 15'd0, "t4 stall");
        end
        @(negedge clk); clear_in(); set_flit(0, 0, 0, 0, 0); set_flit(2, 1, 1, 3, 1);
        cycle(1'b1, 5'b00001, 5'b01000, 15'd0, "t4 resume");
        @(negedge clk); clear_in(); set_flit(0, 0, 1, 0, 0); set_flit(2, 1, 1, 3, 1);
        cycle(1'b1, 5'b00001, 5'b01000, 15'd0, "t4 tail");
        @(negedge clk); clear_in(); set_flit(2, 1, 1, 3, 1);
        cycle(1'b1, 5'b00100, 5'b01000, 15'd1024, "t4 next");

        // Four independent outputs in one cycle
        @(negedge clk); clear_in();
        set_flit(1, 1, 1, 2, 1); set_flit(3, 1, 1, 0, 1);
        set_flit(0, 1, 1, 1, 0); set_flit(2, 1, 1, 1, 2);
        cycle(1'b1, 5'b01111, 5'b11110, 15'd8728, "t5 parallel");

        // Reset in the middle of a 4-flit packet
        @(negedge clk); clear_in(); set_flit(3, 1, 0, 1, 1);
        cycle(1'b1, 5'b01000, 5'b00001, 15'd3, "t6 head");
        @(negedge clk); clear_in(); set_flit(3, 0, 0, 1, 1);
        cycle(1'b1, 5'b01000, 5'b00001, 15'd3, "t6 body");
        for (int b = 0; b < 2; b++) begin
            @(negedge clk); rst = 1'b1; clear_in(); set_flit(3, 0, 0, 1, 1);
            cycle(1'b1, 5'b00000, 5'b00000, 15'd0, "t6 in reset");
        end
        @(negedge clk); rst = 1'b0; clear_in(); set_flit(3, 0, 0, 1, 1); set_flit(2, 1, 1, 1, 1);
        cycle(1'b1, 5'b00100, 5'b00001, 15'd2, "t6 new head");
        @(negedge clk); clear_in(); set_flit(3, 0, 0, 1, 1);
        cycle(1'b1, 5'b00000, 5'b00000, 15'd0, "t6 orphan body");

        // Random traffic
        for (int i = 0; i < N; i++) p_act[i] = 1'b0;
        rst_cnt = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            if (rst_cnt > 0) begin
                rst_cnt--;
                if (rst_cnt == 0) rst = 1'b0;
            end else if ($urandom_range(0, 499) == 0) begin
                rst     = 1'b1;
                rst_cnt = 2;
            end
            for (int i = 0; i < N; i++) begin
                if (!p_act[i]) begin
                    p_act[i] = 1'b1;
                    p_len[i] = $urandom_range(1, 4);
                    p_pos[i] = 0;
                    p_c[i]   = $urandom_range(0, 3);
                    p_r[i]   = $urandom_range(0, 3);
                end
                if ($urandom_range(0, 9) < 7) begin
                    if (p_pos[i] == 0)
                        set_flit(i, 1'b1, p_len[i] == 1, p_c[i], p_r[i]);
                    else
                        set_flit(i, 1'b0, p_pos[i] == p_len[i] - 1,
                                 $urandom_range(0, 15), $urandom_range(0, 15));
                end else begin
                    valid[i]        = 1'b0;
                    head[i]         = 1'($urandom);
                    tail[i]         = 1'($urandom);
                    col[i*CW +: CW] = CW'($urandom);
                    row[i*RW +: RW] = RW'($urandom);
                end
                ready[i] = ($urandom_range(0, 3) != 0);
            end
            cycle(1'b0, 5'b0, 5'b0, 15'd0, "rand");
            for (int i = 0; i < N; i++) begin
                if (rst) begin
                    p_act[i] = 1'b0;
                end else if (exp_grant[i]) begin
                    p_pos[i]++;
                    if (p_pos[i] == p_len[i]) p_act[i] = 1'b0;
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
